boot_slot_ctrl: RTL and testbench

BOOT_SLOT_CTRL -- requirements
Module: boot_slot_ctrl

---
 rtl/boot_pkg.sv | 14 +
 rtl/jumper_debounce.sv | 26 ++
 rtl/boot_slot_ctrl.sv | 83 ++++++++
 tb/tb_boot_slot_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// boot_pkg: state encodings, MesaBus register offsets and key constants for boot_slot_ctrl.
package boot_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HOLDOFF = 3'd1,
        ARMED   = 3'd2,
        FIRE    = 3'd3,
        DONE    = 3'd4
    } state_t;
    localparam logic [7:0]  ADDR_OFS = 8'h2C;
    localparam logic [7:0]  KEY_OFS  = 8'h30;
    localparam logic [31:0] ARM_KEY  = 32'h41524D21;
    localparam logic [31:0] FIRE_KEY = 32'h474F2121;
endpackage

// File: rtl/jumper_debounce.sv
// jumper_debounce: two-flop synchronizer plus saturating low-level debounce counter.
module jumper_debounce #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic reset_l,
    input  logic jp1_l,
    output logic jumper_on
);
    localparam int W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [W-1:0] MAX = W'(DEBOUNCE_CYC);
    logic s1, s2;
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            s1  <= 1'b1;
            s2  <= 1'b1;
            cnt <= '0;
        end else begin
            s1  <= jp1_l;
            s2  <= s1;
            cnt <= s2 ? '0 : (cnt == MAX ? cnt : cnt + 1'b1);
        end
    end
    assign jumper_on = cnt == MAX;
endmodule

// File: rtl/boot_slot_ctrl.sv
// boot_slot_ctrl: one-shot warmboot request, from the debounced boot jumper or an ARM/FIRE key sequence.
module boot_slot_ctrl
    import boot_pkg::*;
#(
    parameter int          I_AM_SLOT0   = 1,
    parameter logic [31:0] SLOT1_ADDR   = 32'h00200000,
    parameter int          DEBOUNCE_CYC = 16,
    parameter int          HOLDOFF_CYC  = 1000,
    parameter int          ARM_TIMEOUT  = 65535
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        jp1_l,
    input  logic        prom_wr,
    input  logic [31:0] prom_addr,
    input  logic [31:0] prom_wr_d,
    output logic        reconfig_req,
    output logic [31:0] reconfig_addr,
    output logic [2:0]  boot_state
);
    localparam int HW = $clog2(HOLDOFF_CYC + 1);
    localparam int AW = $clog2(ARM_TIMEOUT + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYC - 1);
    localparam logic [AW-1:0] ARM_LAST  = AW'(ARM_TIMEOUT);
    state_t state, state_nx;
    logic jumper_on, addr_wr, key_wr, arm_wr, fire_wr, bad_wr, unused;
    logic [HW-1:0] hold_cnt;
    logic [AW-1:0] arm_cnt;
    logic [31:0] slot_addr, target;
    jumper_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
        .clk       (clk),
        .reset_l   (reset_l),
        .jp1_l     (jp1_l),
        .jumper_on (jumper_on)
    );
    assign unused  = ^prom_addr[31:8];
    assign addr_wr = prom_wr && prom_addr[7:0] == ADDR_OFS;
    assign key_wr  = prom_wr && prom_addr[7:0] == KEY_OFS;
    assign arm_wr  = key_wr && prom_wr_d == ARM_KEY;
    assign fire_wr = key_wr && prom_wr_d == FIRE_KEY;
    assign bad_wr  = key_wr && !arm_wr && !fire_wr;
    always_comb begin
        state_nx = state;
        target   = reconfig_addr;
        case (state)
            IDLE:    state_nx = (I_AM_SLOT0 == 1 && jumper_on) ? HOLDOFF : (arm_wr ? ARMED : IDLE);
            HOLDOFF: begin
                if (!jumper_on) state_nx = IDLE;
                else if (hold_cnt == HOLD_LAST) begin
                    state_nx = FIRE;
                    target   = SLOT1_ADDR;
                end
            end
            ARMED: begin
                if (fire_wr) begin
                    state_nx = FIRE;
                    target   = slot_addr;
                end else if (bad_wr || arm_wr || addr_wr || arm_cnt == ARM_LAST) state_nx = IDLE;
            end
            FIRE:    state_nx = DONE;
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    // Counters clear whenever their state is not current, so each entry starts from 0.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state         <= IDLE;
            reconfig_addr <= '0;
            slot_addr     <= '0;
            hold_cnt      <= '0;
            arm_cnt       <= '0;
        end else begin
            state         <= state_nx;
            reconfig_addr <= target;
            slot_addr     <= addr_wr ? {prom_wr_d[31:3], 3'b000} : slot_addr;
            hold_cnt      <= state == HOLDOFF ? hold_cnt + 1'b1 : '0;
            arm_cnt       <= state == ARMED ? arm_cnt + 1'b1 : '0;
        end
    end
    assign reconfig_req = state == FIRE;
    assign boot_state   = state;
endmodule

// File: tb/tb_boot_slot_ctrl.sv
// tb_boot_slot_ctrl: directed vectors for jumper auto-boot, key-sequence boot, aborts and reset behaviour.
module tb_boot_slot_ctrl;
    logic        clk = 1'b0, reset_l = 1'b0, jp1_l = 1'b1, prom_wr = 1'b0;
    logic [31:0] prom_addr = '0, prom_wr_d = '0;
    logic        reconfig_req;
    logic [31:0] reconfig_addr;
    logic [2:0]  boot_state;
    int checks = 0, fails = 0, cyc = 0, req_cnt = 0, req_cyc = 0, t0 = 0;
    logic [31:0] req_addr = '0;
    localparam logic [31:0] ARM = 32'h41524D21, GO = 32'h474F2121;
    boot_slot_ctrl #(
        .I_AM_SLOT0   (1),
        .SLOT1_ADDR   (32'h00200000),
        .DEBOUNCE_CYC (16),
        .HOLDOFF_CYC  (1000),
        .ARM_TIMEOUT  (300)
    ) dut (
        .clk           (clk),
        .reset_l       (reset_l),
        .jp1_l         (jp1_l),
        .prom_wr       (prom_wr),
        .prom_addr     (prom_addr),
        .prom_wr_d     (prom_wr_d),
        .reconfig_req  (reconfig_req),
        .reconfig_addr (reconfig_addr),
        .boot_state    (boot_state)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        if (reconfig_req) begin
            req_cnt  = req_cnt + 1;
            req_addr = reconfig_addr;
            req_cyc  = cyc;
        end
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic do_reset(input logic jp);
        jp1_l   = jp;
        reset_l = 1'b0;
        repeat (3) @(negedge clk);
        req_cnt = 0;
        chk("rst_state", 32'(boot_state), 0);
        chk("rst_req", 32'(reconfig_req), 0);
        chk("rst_addr", reconfig_addr, 0);
        reset_l = 1'b1;
        t0 = cyc;
    endtask
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        prom_wr   = 1'b1;
        prom_addr = {24'h123456, a};
        prom_wr_d = d;
        @(negedge clk);
        prom_wr = 1'b0;
    endtask
    task automatic wait_req(input int lim);
        for (int i = 0; i < lim && req_cnt == 0; i++) @(negedge clk);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        // jumper auto-boot from reset
        do_reset(1'b0);
        wait_req(1100);
        chk("auto_cnt", req_cnt, 1);
        chk("auto_addr", req_addr, 32'h00200000);
        chk("auto_lat", req_cyc - t0, 1019);
        repeat (5) @(negedge clk);
        chk("auto_once", req_cnt, 1);
        chk("auto_done", 32'(boot_state), 4);
        chk("addr_hold", reconfig_addr, 32'h00200000);
        // reset mid-holdoff at count 500
        do_reset(1'b0);
        repeat (519) @(negedge clk);
        chk("ho_state", 32'(boot_state), 1);
        #2 reset_l = 1'b0;
        #1;
        chk("abort_state", 32'(boot_state), 0);
        chk("abort_req", 32'(reconfig_req), 0);
        chk("abort_addr", reconfig_addr, 0);
        chk("abort_nreq", req_cnt, 0);
        do_reset(1'b0);
        repeat (1018) @(negedge clk);
        chk("re_early", req_cnt, 0);
        wait_req(10);
        chk("re_cnt", req_cnt, 1);
        chk("re_lat", req_cyc - t0, 1019);
        // short jumper glitch
        do_reset(1'b1);
        @(negedge clk);
        jp1_l = 1'b0;
        repeat (10) @(negedge clk);
        jp1_l = 1'b1;
        repeat (1100) @(negedge clk);
        chk("glitch_req", req_cnt, 0);
        chk("glitch_state", 32'(boot_state), 0);
        // software boot to slot_addr
        do_reset(1'b1);
        wr(8'h2C, 32'h00400007);
        wr(8'h30, ARM);
        chk("sw_armed", 32'(boot_state), 2);
        repeat (5) @(negedge clk);
        wr(8'h30, GO);
        wait_req(5);
        chk("sw_cnt", req_cnt, 1);
        chk("sw_addr", req_addr, 32'h00400000);
        repeat (2) @(negedge clk);
        chk("sw_done", 32'(boot_state), 4);
        wr(8'h30, ARM);
        wr(8'h30, GO);
        repeat (3) @(negedge clk);
        chk("done_once", req_cnt, 1);
        chk("done_stay", 32'(boot_state), 4);
        // arm timeout
        do_reset(1'b1);
        wr(8'h30, ARM);
        repeat (299) @(negedge clk);
        chk("to_armed", 32'(boot_state), 2);
        repeat (2) @(negedge clk);
        chk("to_idle", 32'(boot_state), 0);
        wr(8'h30, GO);
        repeat (3) @(negedge clk);
        chk("to_req", req_cnt, 0);
        chk("to_state", 32'(boot_state), 0);
        // bad key, second ARM and address write all disarm
        do_reset(1'b1);
        wr(8'h30, ARM);
        wr(8'h30, 32'hDEADBEEF);
        chk("bad_idle", 32'(boot_state), 0);
        wr(8'h30, GO);
        repeat (3) @(negedge clk);
        chk("bad_req", req_cnt, 0);
        chk("bad_state", 32'(boot_state), 0);
        wr(8'h30, ARM);
        wr(8'h30, ARM);
        chk("rearm_idle", 32'(boot_state), 0);
        wr(8'h30, ARM);
        wr(8'h2C, 32'h00800000);
        chk("addrwr_idle", 32'(boot_state), 0);
        chk("addrwr_req", req_cnt, 0);
        // jumper and ARM in the same cycle, then keys ignored in holdoff
        do_reset(1'b0);
        repeat (18) @(negedge clk);
        prom_wr   = 1'b1;
        prom_addr = 32'h00000030;
        prom_wr_d = ARM;
        @(negedge clk);
        prom_wr = 1'b0;
        chk("tie_holdoff", 32'(boot_state), 1);
        wr(8'h30, GO);
        chk("ho_ignore", 32'(boot_state), 1);
        wait_req(1100);
        chk("tie_cnt", req_cnt, 1);
        chk("tie_addr", req_addr, 32'h00200000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
